// File: rtl/bids22_cmd_sequencer.sv
// bids22_cmd_sequencer
//
// Host-side command sequencer for the bids22 bidmaster control port. Host commands are
// buffered in a small FIFO and issued one at a time on C_op/C_data with a one-cycle C_start
// strobe. The sequencer then waits for the bidmaster to come back ready, or gives up after
// TIMEOUT_CYCLES, and returns one response (opcode plus error code) per issued command on a
// valid/ready channel. Only one command is ever outstanding at the bidmaster.
//
// Ports
//   clk, reset_n          single rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   host command handshake; cmd_op (4b) and cmd_data (DATAWIDTH b)
//   flush_on_err          drop all queued commands after an error response is accepted
//   C_op/C_data/C_start   command issued to the bidmaster; C_start is a one-cycle strobe
//   bm_ready, bm_err      bidmaster ready and error code (outerrors_t)
//   rsp_valid/rsp_ready   response handshake; rsp_op, rsp_err (3'd7 = timeout)
//   busy                  sequencer active or commands still queued
module bids22_cmd_sequencer #(
  parameter int unsigned DATAWIDTH      = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [DATAWIDTH-1:0] cmd_data,
  input  logic                 flush_on_err,
  output logic [3:0]           C_op,
  output logic [DATAWIDTH-1:0] C_data,
  output logic                 C_start,
  input  logic                 bm_ready,
  input  logic [2:0]           bm_err,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_op,
  output logic [2:0]           rsp_err,
  output logic                 busy
);

  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  // Leaving WAIT from this timer value lands the timeout response exactly
  // TIMEOUT_CYCLES cycles after the C_start cycle.
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
  // First WAIT cycle (timer == 1) is blanked; bm_ready is honoured from timer == 2.
  localparam logic [TimerW-1:0] FirstLive   = TimerW'(2);
  localparam logic [2:0]        ErrTimeout  = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResp,
    StFlush
  } state_e;

  state_e state_q, state_d;

  logic [TimerW-1:0]    timer_q, timer_d;
  logic [3:0]           c_op_q, c_op_d;
  logic [DATAWIDTH-1:0] c_data_q, c_data_d;
  logic                 c_start_q, c_start_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [3:0]           rsp_op_q, rsp_op_d;
  logic [2:0]           rsp_err_q, rsp_err_d;

  // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [3:0]           op_mem   [FIFO_DEPTH];
  logic [DATAWIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [AddrW:0]       wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]       rd_ptr_q, rd_ptr_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic flush;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  // Readiness depends on registered state only, so a pop in the same cycle never
  // opens a slot for a simultaneous push.
  assign cmd_ready = !fifo_full && (state_q != StFlush);
  assign push      = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q[AddrW-1:0]]   <= cmd_op;
      data_mem[wr_ptr_q[AddrW-1:0]] <= cmd_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Sequencer next state; all bidmaster and response outputs are registered.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    c_op_d      = c_op_q;
    c_data_d    = c_data_q;
    c_start_d   = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_op_d    = rsp_op_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    flush       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && bm_ready) begin
          state_d   = StIssue;
          c_op_d    = op_mem[rd_ptr_q[AddrW-1:0]];
          c_data_d  = data_mem[rd_ptr_q[AddrW-1:0]];
          c_start_d = 1'b1;
          timer_d   = '0;
        end
      end
      StIssue: begin
        pop     = 1'b1;
        timer_d = timer_q + 1'b1;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        if (bm_ready && (timer_q >= FirstLive)) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_op_d    = c_op_q;
          rsp_err_d   = bm_err;
        end else if (timer_q >= TimeoutLast) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_op_d    = c_op_q;
          rsp_err_d   = ErrTimeout;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ((rsp_err_q != 3'd0) && flush_on_err) ? StFlush : StIdle;
        end
      end
      StFlush: begin
        flush   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      c_op_q      <= '0;
      c_data_q    <= '0;
      c_start_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_err_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      c_op_q      <= c_op_d;
      c_data_q    <= c_data_d;
      c_start_q   <= c_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_err_q   <= rsp_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  assign C_op      = c_op_q;
  assign C_data    = c_data_q;
  assign C_start   = c_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_bids22_cmd_sequencer.sv
// Bench for bids22_cmd_sequencer: a cycle table for the basic single-command flow, then
// directed sequences for FIFO backpressure, flush on error, timeout, response stall and
// asynchronous reset while a command is outstanding.
module tb_bids22_cmd_sequencer;

  localparam int unsigned DW  = 32;
  localparam int unsigned Tmo = 64;
  localparam logic [31:0] Key = 32'hC0DE_1234;

  logic          clk;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          flush_on_err;
  logic [3:0]    C_op;
  logic [DW-1:0] C_data;
  logic          C_start;
  logic          bm_ready;
  logic [2:0]    bm_err;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [3:0]    rsp_op;
  logic [2:0]    rsp_err;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  bids22_cmd_sequencer #(
    .DATAWIDTH      (DW),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .flush_on_err (flush_on_err),
    .C_op         (C_op),
    .C_data       (C_data),
    .C_start      (C_start),
    .bm_ready     (bm_ready),
    .bm_err       (bm_err),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_op       (rsp_op),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [3:0]    op;
    logic [DW-1:0] data;
    logic          rdy;
    logic [2:0]    err;
    logic          rrdy;
    logic          e_cr;
    logic          e_st;
    logic [3:0]    e_op;
    logic [DW-1:0] e_data;
    logic          e_rv;
    logic [3:0]    e_rop;
    logic [2:0]    e_rerr;
    logic          e_busy;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [63:0] pack(input logic cr, input logic st, input logic [3:0] op,
                                       input logic [DW-1:0] data, input logic rv,
                                       input logic [3:0] rop, input logic [2:0] rerr,
                                       input logic bsy);
    return 64'({cr, st, op, data, rv, rop, rerr, bsy});
  endfunction

  function automatic logic [63:0] pack_dut();
    return pack(cmd_ready, C_start, C_op, C_data, rsp_valid, rsp_op, rsp_err, busy);
  endfunction

  function automatic logic [DW-1:0] dat(input logic [3:0] op);
    return {28'hDA7A000, op};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = dat(op);
    @(negedge clk);
    check("push_ready", 64'(cmd_ready), 64'(1'b1));
    step();
    cmd_valid = 1'b0;
  endtask

  // Waits for a response, optionally holds it off for 'hold' cycles, then accepts it.
  // Returns just after the edge that follows the handshake.
  task automatic get_rsp(input logic [3:0] op, input logic [2:0] err, input int hold);
    int n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 100) begin
      step();
      @(negedge clk);
      n++;
    end
    check("rsp_valid", 64'(rsp_valid), 64'(1'b1));
    check("rsp_op_err", 64'({rsp_op, rsp_err}), 64'({op, err}));
    for (int i = 0; i < hold; i++) begin
      step();
      @(negedge clk);
      check("rsp_hold", 64'({rsp_valid, rsp_op, rsp_err, C_start}), 64'({1'b1, op, err, 1'b0}));
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    step();
    rsp_ready = 1'b0;
  endtask

  // Entered at the sampling point of the C_start cycle. A ready pulse inside the
  // blanking cycle carries a marker error that must never be captured.
  task automatic finish_cmd(input logic [3:0] op, input logic [2:0] err, input int delay,
                            input int hold);
    step();
    bm_ready = 1'b1;
    bm_err   = 3'd5;
    for (int i = 0; i < delay; i++) begin
      step();
      bm_ready = 1'b0;
    end
    step();
    bm_ready = 1'b1;
    bm_err   = err;
    get_rsp(op, err, hold);
  endtask

  task automatic wait_start(input logic [3:0] op);
    int n = 0;
    bm_ready = 1'b1;
    @(negedge clk);
    while (C_start !== 1'b1 && n < 100) begin
      step();
      @(negedge clk);
      n++;
    end
    check("c_start", 64'(C_start), 64'(1'b1));
    check("c_op_data", 64'({C_op, C_data}), 64'({op, dat(op)}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n;
    int c_cnt;
    int r_cnt;
    int b_cnt;

    reset_n      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = '0;
    cmd_data     = '0;
    flush_on_err = 1'b0;
    bm_ready     = 1'b0;
    bm_err       = '0;
    rsp_ready    = 1'b0;

    // UNLOCK with key; bidmaster ready returns 3 cycles after C_start.
    //             v     op    data   rdy   err   rrdy  cr    st    op    data   rv    rop   rerr  busy
    vecs[0] = '{1'b1, 4'd1, Key,   1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 3'd0, 1'b0};
    vecs[1] = '{1'b0, 4'd0, 32'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 3'd0, 1'b1};
    vecs[2] = '{1'b0, 4'd0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 4'd1, Key,   1'b0, 4'd0, 3'd0, 1'b1};
    vecs[3] = '{1'b0, 4'd0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd1, Key,   1'b0, 4'd0, 3'd0, 1'b1};
    vecs[4] = '{1'b0, 4'd0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd1, Key,   1'b0, 4'd0, 3'd0, 1'b1};
    vecs[5] = '{1'b0, 4'd0, 32'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 4'd1, Key,   1'b0, 4'd0, 3'd0, 1'b1};
    vecs[6] = '{1'b0, 4'd0, 32'd0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 4'd1, Key,   1'b1, 4'd1, 3'd0, 1'b1};
    vecs[7] = '{1'b0, 4'd0, 32'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 4'd1, Key,   1'b0, 4'd1, 3'd0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", pack_dut(), pack(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 3'd0, 1'b0));
    step();
    reset_n = 1'b1;

    // Single UNLOCK command, cycle by cycle.
    for (int i = 0; i < 8; i++) begin
      cmd_valid = vecs[i].v;
      cmd_op    = vecs[i].op;
      cmd_data  = vecs[i].data;
      bm_ready  = vecs[i].rdy;
      bm_err    = vecs[i].err;
      rsp_ready = vecs[i].rrdy;
      @(negedge clk);
      check($sformatf("unlock_cycle%0d", i), pack_dut(),
            pack(vecs[i].e_cr, vecs[i].e_st, vecs[i].e_op, vecs[i].e_data, vecs[i].e_rv,
                 vecs[i].e_rop, vecs[i].e_rerr, vecs[i].e_busy));
      step();
    end
    rsp_ready = 1'b0;

    // Fill the FIFO with the bidmaster stalled; a fifth command waits for the first pop.
    bm_ready = 1'b0;
    push(4'd2);
    push(4'd3);
    push(4'd4);
    push(4'd5);
    cmd_valid = 1'b1;
    cmd_op    = 4'd6;
    cmd_data  = dat(4'd6);
    @(negedge clk);
    check("full_ready", 64'(cmd_ready), 64'(1'b0));
    step();
    @(negedge clk);
    check("full_stall", 64'({cmd_ready, busy}), 64'({1'b0, 1'b1}));
    step();
    bm_ready = 1'b1;
    @(negedge clk);
    check("full_idle", 64'({cmd_ready, C_start}), 64'({1'b0, 1'b0}));
    step();
    @(negedge clk);
    check("full_issue", 64'({cmd_ready, C_start, C_op}), 64'({1'b0, 1'b1, 4'd2}));
    step();
    @(negedge clk);
    check("slot_freed", 64'(cmd_ready), 64'(1'b1));
    step();
    cmd_valid = 1'b0;
    bm_ready  = 1'b1;
    bm_err    = 3'd0;
    get_rsp(4'd2, 3'd0, 0);
    for (int k = 3; k <= 6; k++) begin
      wait_start(4'(k));
      finish_cmd(4'(k), 3'd0, 1, 0);
    end

    // Error on LOADX with flush enabled drops LOADY/LOADZ.
    flush_on_err = 1'b1;
    bm_ready     = 1'b0;
    push(4'd3);
    push(4'd4);
    push(4'd5);
    wait_start(4'd3);
    finish_cmd(4'd3, 3'd3, 1, 0);
    @(negedge clk);
    check("flush_cycle", 64'({cmd_ready, rsp_valid, busy}), 64'({1'b0, 1'b0, 1'b1}));
    step();
    @(negedge clk);
    check("flush_empty", 64'({cmd_ready, busy}), 64'({1'b1, 1'b0}));
    c_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      @(negedge clk);
      if (C_start === 1'b1) c_cnt++;
    end
    check("flush_no_start", 64'(c_cnt), 64'(0));
    step();
    flush_on_err = 1'b0;

    // Timeout; the queued command goes out once the bidmaster is ready again.
    bm_ready = 1'b0;
    push(4'd9);
    push(4'd10);
    wait_start(4'd9);
    step();
    bm_ready = 1'b0;
    n = 1;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 200) begin
      step();
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 64'(n), 64'(Tmo));
    check("timeout_rsp", 64'({rsp_valid, rsp_op, rsp_err}), 64'({1'b1, 4'd9, 3'd7}));
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    step();
    rsp_ready = 1'b0;
    c_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (C_start === 1'b1) c_cnt++;
      step();
    end
    @(negedge clk);
    check("tmo_held", 64'({c_cnt[3:0], busy}), 64'({4'd0, 1'b1}));
    step();
    bm_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    check("tmo_next_issue", 64'({C_start, C_op}), 64'({1'b1, 4'd10}));
    finish_cmd(4'd10, 3'd0, 0, 0);

    // Host stalls the response; nothing new may issue meanwhile.
    bm_ready = 1'b0;
    push(4'd6);
    push(4'd7);
    wait_start(4'd6);
    finish_cmd(4'd6, 3'd2, 2, 10);
    wait_start(4'd7);
    finish_cmd(4'd7, 3'd0, 0, 0);

    // Asynchronous reset during WAIT with two commands still queued.
    bm_ready = 1'b0;
    push(4'd11);
    push(4'd12);
    push(4'd13);
    wait_start(4'd11);
    step();
    bm_ready = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", pack_dut(), pack(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 3'd0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    bm_ready = 1'b1;
    c_cnt = 0;
    r_cnt = 0;
    b_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (C_start === 1'b1) c_cnt++;
      if (rsp_valid === 1'b1) r_cnt++;
      if (busy === 1'b1) b_cnt++;
      step();
    end
    check("post_reset_quiet", 64'({c_cnt[7:0], r_cnt[7:0], b_cnt[7:0]}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
